// File: rtl/br_pkg.sv
// ////////////////////////////////////////////////////////////////
// br_pkg: branch type encoding and shared defaults | rev 1.0
// ////////////////////////////////////////////////////////////////
`default_nettype none

package br_pkg;

   localparam int C_XLEN = 32;

   typedef enum logic [2:0] {
      BR_NONE = 3'b000,
      BR_BEQ  = 3'b001,
      BR_BNE  = 3'b010,
      BR_BLT  = 3'b011,
      BR_BGE  = 3'b100,
      BR_BLTU = 3'b101,
      BR_BGEU = 3'b110,
      BR_JUMP = 3'b111
   } br_type_e;

endpackage

`default_nettype wire

// File: rtl/branch_resolve_unit_if.sv
// ////////////////////////////////////////////////////////////////
// branch_resolve_unit_if: EX-stage request and resolved-branch result bus | rev 1.0
// ////////////////////////////////////////////////////////////////
`default_nettype none

interface branch_resolve_unit_if #(
   parameter int XLEN = br_pkg::C_XLEN
);
   logic            valid_i;
   logic            stall_i;
   logic            flush_i;
   logic [2:0]      br_type_i;
   logic [XLEN-1:0] rdata1_i;
   logic [XLEN-1:0] rdata2_i;
   logic [XLEN-1:0] pc_i;
   logic [XLEN-1:0] target_i;
   logic            pred_taken_i;
   logic [XLEN-1:0] pred_target_i;
   logic            valid_o;
   logic            br_taken_o;
   logic            redirect_o;
   logic [XLEN-1:0] redirect_pc_o;

   modport master (
      output valid_i, stall_i, flush_i, br_type_i, rdata1_i, rdata2_i,
             pc_i, target_i, pred_taken_i, pred_target_i,
      input  valid_o, br_taken_o, redirect_o, redirect_pc_o
   );

   modport slave (
      input  valid_i, stall_i, flush_i, br_type_i, rdata1_i, rdata2_i,
             pc_i, target_i, pred_taken_i, pred_target_i,
      output valid_o, br_taken_o, redirect_o, redirect_pc_o
   );
endinterface

`default_nettype wire

// File: rtl/br_compare.sv
// ////////////////////////////////////////////////////////////////
// br_compare: combinational branch condition evaluation | rev 1.0
// ////////////////////////////////////////////////////////////////
`default_nettype none

module br_compare
   import br_pkg::*;
#(
   parameter int XLEN = C_XLEN
) (
   input  wire br_type_e        br_type_i,
   input  wire logic [XLEN-1:0] rdata1_i,
   input  wire logic [XLEN-1:0] rdata2_i,
   output logic                 taken_o
);

   always_comb begin
      taken_o = 1'b0;
      case (br_type_i)
         BR_NONE: taken_o = 1'b0;
         BR_BEQ:  taken_o = (rdata1_i == rdata2_i);
         BR_BNE:  taken_o = (rdata1_i != rdata2_i);
         BR_BLT:  taken_o = ($signed(rdata1_i) <  $signed(rdata2_i));
         BR_BGE:  taken_o = ($signed(rdata1_i) >= $signed(rdata2_i));
         BR_BLTU: taken_o = (rdata1_i <  rdata2_i);
         BR_BGEU: taken_o = (rdata1_i >= rdata2_i);
         BR_JUMP: taken_o = 1'b1;
         default: taken_o = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ////////////////////////////////////////////////////////////////
// branch_resolve_unit: registered branch resolution, redirect on mispredict;
// optional saturating counters under BR_PERF_CNT_EN | rev 1.0
// ////////////////////////////////////////////////////////////////
`default_nettype none

module branch_resolve_unit
   import br_pkg::*;
#(
   parameter int XLEN        = C_XLEN,
   parameter int INSTR_BYTES = 4
`ifdef BR_PERF_CNT_EN
   ,
   parameter int CNT_W       = 32
`endif
) (
   input  wire logic               clk,
   input  wire logic               rst_n,
   branch_resolve_unit_if.slave    bus
`ifdef BR_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]        br_count_o,
   output logic [CNT_W-1:0]        mispred_count_o
`endif
);

   br_type_e        w_br_type;
   logic            w_cmp_taken;
   logic            w_is_branch;
   logic            w_mispred;
   logic            w_load;
   logic [XLEN-1:0] w_fallthrough;
   logic [XLEN-1:0] w_next_pc;

   logic            r_valid;
   logic            r_taken;
   logic            r_redirect;
   logic [XLEN-1:0] r_redirect_pc;

   assign w_br_type = br_type_e'(bus.br_type_i);

   br_compare #(
      .XLEN (XLEN)
   ) u_br_compare (
      .br_type_i (w_br_type),
      .rdata1_i  (bus.rdata1_i),
      .rdata2_i  (bus.rdata2_i),
      .taken_o   (w_cmp_taken)
   );

   // Fall-through wraps at 2^XLEN; the carry is deliberately dropped.
   assign w_fallthrough = bus.pc_i + XLEN'(INSTR_BYTES);
   assign w_next_pc     = w_cmp_taken ? bus.target_i : w_fallthrough;
   assign w_is_branch   = bus.valid_i && (w_br_type != BR_NONE);
   assign w_mispred     = w_is_branch &&
                          ((w_cmp_taken != bus.pred_taken_i) ||
                           (w_cmp_taken && (bus.target_i != bus.pred_target_i)));
   assign w_load        = !bus.flush_i && !bus.stall_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid       <= 1'b0;
         r_taken       <= 1'b0;
         r_redirect    <= 1'b0;
         r_redirect_pc <= '0;
      end else if (bus.flush_i) begin
         r_valid    <= 1'b0;
         r_taken    <= 1'b0;
         r_redirect <= 1'b0;
      end else if (!bus.stall_i) begin
         r_valid       <= bus.valid_i;
         r_taken       <= bus.valid_i && w_cmp_taken;
         r_redirect    <= w_mispred;
         r_redirect_pc <= w_next_pc;
      end
   end

   assign bus.valid_o       = r_valid;
   assign bus.br_taken_o    = r_taken;
   assign bus.redirect_o    = r_redirect;
   assign bus.redirect_pc_o = r_redirect_pc;

`ifdef BR_PERF_CNT_EN
   logic [CNT_W-1:0] r_br_count;
   logic [CNT_W-1:0] r_mispred_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_br_count      <= '0;
         r_mispred_count <= '0;
      end else if (w_load && w_is_branch) begin
         if (r_br_count != '1) begin
            r_br_count <= r_br_count + 1'b1;
         end
         if (w_mispred && (r_mispred_count != '1)) begin
            r_mispred_count <= r_mispred_count + 1'b1;
         end
      end
   end

   assign br_count_o      = r_br_count;
   assign mispred_count_o = r_mispred_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ////////////////////////////////////////////////////////////////
// tb_branch_resolve_unit: directed vectors plus stall/flush/reset sequences | rev 1.0
// ////////////////////////////////////////////////////////////////
`default_nettype none

module tb_branch_resolve_unit;
   import br_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

`ifdef BR_PERF_CNT_EN
   logic [3:0] br_count;
   logic [3:0] mispred_count;
`endif

   branch_resolve_unit_if #(.XLEN(32)) bus ();

   branch_resolve_unit #(
      .XLEN        (32),
      .INSTR_BYTES (4)
`ifdef BR_PERF_CNT_EN
      ,
      .CNT_W       (4)
`endif
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef BR_PERF_CNT_EN
      ,
      .br_count_o      (br_count),
      .mispred_count_o (mispred_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      br_type_e    t;
      logic        v;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [31:0] pc;
      logic [31:0] tg;
      logic        pt;
      logic [31:0] ptg;
      logic        e_valid;
      logic        e_taken;
      logic        e_redir;
      logic        chk_pc;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input br_type_e t, input logic v, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] pc, input logic [31:0] tg,
                        input logic pt, input logic [31:0] ptg);
      @(negedge clk);
      bus.br_type_i     = t;
      bus.valid_i       = v;
      bus.rdata1_i      = r1;
      bus.rdata2_i      = r2;
      bus.pc_i          = pc;
      bus.target_i      = tg;
      bus.pred_taken_i  = pt;
      bus.pred_target_i = ptg;
      bus.stall_i       = 1'b0;
      bus.flush_i       = 1'b0;
   endtask

   task automatic sample();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      //           type     v  rdata1         rdata2         pc             target         pt pred_tgt      ev et er cp e_pc
      vecs[0]  = '{BR_BLT,  1, 32'hFFFFFFFF, 32'h1,        32'h40,        32'h100,       0, 32'h0,        1, 1, 1, 1, 32'h100};
      vecs[1]  = '{BR_BLTU, 1, 32'hFFFFFFFF, 32'h1,        32'h40,        32'h100,       0, 32'h0,        1, 0, 0, 1, 32'h44};
      vecs[2]  = '{BR_BNE,  1, 32'h5,        32'h5,        32'hFFFFFFFC,  32'h80,        1, 32'h80,       1, 0, 1, 1, 32'h0};
      vecs[3]  = '{BR_JUMP, 1, 32'h0,        32'h0,        32'h10,        32'h204,       1, 32'h200,      1, 1, 1, 1, 32'h204};
      vecs[4]  = '{BR_JUMP, 1, 32'h0,        32'h0,        32'h10,        32'h204,       1, 32'h204,      1, 1, 0, 1, 32'h204};
      vecs[5]  = '{BR_BEQ,  1, 32'h7,        32'h7,        32'h20,        32'h300,       1, 32'h300,      1, 1, 0, 1, 32'h300};
      vecs[6]  = '{BR_BGE,  1, 32'hFFFFFFFF, 32'h1,        32'h50,        32'h500,       0, 32'h0,        1, 0, 0, 1, 32'h54};
      vecs[7]  = '{BR_BGEU, 1, 32'hFFFFFFFF, 32'h1,        32'h50,        32'h600,       0, 32'h0,        1, 1, 1, 1, 32'h600};
      vecs[8]  = '{BR_NONE, 1, 32'h0,        32'h0,        32'h60,        32'h123,       1, 32'h123,      1, 0, 0, 1, 32'h64};
      vecs[9]  = '{BR_BEQ,  0, 32'h9,        32'h9,        32'h60,        32'h800,       0, 32'h0,        0, 0, 0, 0, 32'h0};
      vecs[10] = '{BR_BGE,  1, 32'h3,        32'h3,        32'h68,        32'h700,       1, 32'h700,      1, 1, 0, 1, 32'h700};
      vecs[11] = '{BR_BLT,  1, 32'h1,        32'hFFFFFFFF, 32'h70,        32'h900,       1, 32'h900,      1, 0, 1, 1, 32'h74};

      rst_n             = 1'b0;
      bus.valid_i       = 1'b0;
      bus.stall_i       = 1'b0;
      bus.flush_i       = 1'b0;
      bus.br_type_i     = BR_NONE;
      bus.rdata1_i      = '0;
      bus.rdata2_i      = '0;
      bus.pc_i          = '0;
      bus.target_i      = '0;
      bus.pred_taken_i  = 1'b0;
      bus.pred_target_i = '0;
      #12;
      chk("reset valid",    {31'd0, bus.valid_o},    32'd0);
      chk("reset taken",    {31'd0, bus.br_taken_o}, 32'd0);
      chk("reset redirect", {31'd0, bus.redirect_o}, 32'd0);
      chk("reset pc",       bus.redirect_pc_o,       32'd0);
`ifdef BR_PERF_CNT_EN
      chk("reset br_count",      {28'd0, br_count},      32'd0);
      chk("reset mispred_count", {28'd0, mispred_count}, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].t, vecs[i].v, vecs[i].r1, vecs[i].r2, vecs[i].pc,
               vecs[i].tg, vecs[i].pt, vecs[i].ptg);
         sample();
         chk($sformatf("vec%0d valid", i),    {31'd0, bus.valid_o},    {31'd0, vecs[i].e_valid});
         chk($sformatf("vec%0d taken", i),    {31'd0, bus.br_taken_o}, {31'd0, vecs[i].e_taken});
         chk($sformatf("vec%0d redirect", i), {31'd0, bus.redirect_o}, {31'd0, vecs[i].e_redir});
         if (vecs[i].chk_pc) begin
            chk($sformatf("vec%0d redirect_pc", i), bus.redirect_pc_o, vecs[i].e_pc);
         end
      end

      // Mispredicted BEQ held by a 3-cycle stall while new inputs arrive.
      drive(BR_BEQ, 1, 32'h8, 32'h8, 32'h80, 32'h900, 0, 32'h0);
      sample();
      chk("stall load redirect", {31'd0, bus.redirect_o}, 32'd1);
      for (int c = 0; c < 3; c++) begin
         drive(BR_BNE, 0, 32'h1, 32'h2, 32'h90, 32'hA00, 0, 32'h0);
         bus.stall_i = 1'b1;
         sample();
         chk($sformatf("stall%0d redirect", c), {31'd0, bus.redirect_o}, 32'd1);
         chk($sformatf("stall%0d valid", c),    {31'd0, bus.valid_o},    32'd1);
         chk($sformatf("stall%0d pc", c),       bus.redirect_pc_o,       32'h900);
      end
      drive(BR_BNE, 1, 32'h1, 32'h2, 32'h90, 32'hA00, 0, 32'h0);
      bus.stall_i = 1'b1;
      bus.flush_i = 1'b1;
      sample();
      chk("flush+stall valid",    {31'd0, bus.valid_o},    32'd0);
      chk("flush+stall redirect", {31'd0, bus.redirect_o}, 32'd0);
      chk("flush+stall taken",    {31'd0, bus.br_taken_o}, 32'd0);
      chk("flush+stall pc hold",  bus.redirect_pc_o,       32'h900);

      // Asynchronous reset between edges while a redirect is showing.
      drive(BR_JUMP, 1, 32'h0, 32'h0, 32'hA0, 32'hB00, 0, 32'h0);
      sample();
      chk("pre-reset redirect", {31'd0, bus.redirect_o}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset valid",    {31'd0, bus.valid_o},    32'd0);
      chk("async reset redirect", {31'd0, bus.redirect_o}, 32'd0);
      chk("async reset taken",    {31'd0, bus.br_taken_o}, 32'd0);
      chk("async reset pc",       bus.redirect_pc_o,       32'd0);
      @(negedge clk);
      bus.valid_i = 1'b0;
      rst_n       = 1'b1;

`ifdef BR_PERF_CNT_EN
      // Three mispredicts, one correct prediction, then NONE and a stalled branch.
      for (int k = 0; k < 3; k++) begin
         drive(BR_BEQ, 1, 32'h1, 32'h2, 32'h100, 32'h200, 1, 32'h200);
         sample();
      end
      chk("cnt3 br",      {28'd0, br_count},      32'd3);
      chk("cnt3 mispred", {28'd0, mispred_count}, 32'd3);
      drive(BR_BNE, 1, 32'h1, 32'h2, 32'h100, 32'h200, 1, 32'h200);
      sample();
      chk("cnt4 br",      {28'd0, br_count},      32'd4);
      chk("cnt4 mispred", {28'd0, mispred_count}, 32'd3);
      drive(BR_NONE, 1, 32'h0, 32'h0, 32'h100, 32'h200, 1, 32'h200);
      sample();
      drive(BR_BEQ, 1, 32'h1, 32'h2, 32'h100, 32'h200, 1, 32'h200);
      bus.stall_i = 1'b1;
      sample();
      drive(BR_BEQ, 1, 32'h1, 32'h2, 32'h100, 32'h200, 1, 32'h200);
      bus.flush_i = 1'b1;
      sample();
      chk("cnt hold br",      {28'd0, br_count},      32'd4);
      chk("cnt hold mispred", {28'd0, mispred_count}, 32'd3);
      for (int k = 0; k < 20; k++) begin
         drive(BR_BEQ, 1, 32'h1, 32'h2, 32'h100, 32'h200, 1, 32'h200);
         sample();
      end
      chk("cnt sat br",      {28'd0, br_count},      32'd15);
      chk("cnt sat mispred", {28'd0, mispred_count}, 32'd15);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised, registered branch-resolution stage for the execute side of the pipelined core. It evaluates the branch condition for the instruction in EX and compares the outcome against the fetch-stage prediction. It then produces a one-cycle-latency redirect/flush request together with the corrected next PC. Optional saturating performance counters track branch count and mispredictions.

## Interface
- `XLEN`, 32: operand and PC width.
- `CNT_W`, 32: width of each performance counter.
- `INSTR_BYTES`, 4: fall-through increment added to `pc_i`.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `valid_i` input 1: EX-stage instruction valid.
- `stall_i` input 1: hold the output register.
- `flush_i` input 1: kill the incoming and held instruction.
- `br_type_i` input 3: branch type (encoding in package).
- `rdata1_i`, `rdata2_i` input XLEN: comparison operands.
- `pc_i` input XLEN: PC of the EX instruction.
- `target_i` input XLEN: computed branch/jump target.
- `pred_taken_i` input 1: fetch prediction direction.
- `pred_target_i` input XLEN: fetch prediction target.
- `valid_o` output 1: registered result valid.
- `br_taken_o` output 1: resolved direction.
- `redirect_o` output 1: misprediction, fetch must restart.
- `redirect_pc_o` output XLEN: correct next PC.
- `br_count_o`, `mispred_count_o` output CNT_W: counters. Present only with `BR_PERF_CNT_EN`.

## Operation
- `br_type` encoding (3 bits):
  - 000 NONE: not taken.
  - 001 BEQ, 010 BNE.
  - 011 BLT, 100 BGE: signed compare.
  - 101 BLTU, 110 BGEU: unsigned compare.
  - 111 JUMP: always taken.
- Branch instruction: `valid_i` high and type not NONE.
- Taken = comparator result.
- Correct PC:
  - taken: `target_i`.
  - not taken: `pc_i + INSTR_BYTES`, XLEN bits, wraps modulo 2^XLEN with no carry out.
- Mispredict, evaluated only for branch instructions, if either holds:
  - taken differs from `pred_taken_i`;
  - both taken, and `target_i` differs from `pred_target_i`.
- NONE with `valid_i` high: `valid_o` is 1, `br_taken_o` is 0, `redirect_o` is 0. Never redirects regardless of prediction.
- Output register update priority, evaluated each edge:
  1. `flush_i` high: `valid_o`, `br_taken_o` and `redirect_o` clear. `redirect_pc_o` holds.
  2. `stall_i` high: all outputs hold their values.
  3. Otherwise: load from the current inputs. `valid_o` takes `valid_i`. When `valid_i` is low, `br_taken_o` and `redirect_o` load 0.
- `flush_i` together with `stall_i`: flush wins.
- `redirect_o` is never high while `valid_o` is low.

## Timing
- Latency: exactly 1 cycle from input sampling to outputs. Outputs are registered, with no combinational input-to-output path.
- During a stall, the held redirect stays asserted. The consumer must accept it once, on the first cycle only.
- Reset (async assert, sync-released by the top level):
  - `valid_o`, `br_taken_o`, `redirect_o`: 0.
  - `redirect_pc_o`: 0.
  - Counters: 0.
- Reset asserted mid-operation clears everything immediately, with no clock edge needed.
- Throughput: one instruction per cycle when not stalled.

## Configuration
- `BR_PERF_CNT_EN` defined:
  - `br_count_o` increments on every register load of a branch instruction. Stalled or flushed cycles do not count.
  - `mispred_count_o` increments when that load also sets `redirect_o`.
  - Both saturate at 2^CNT_W−1; no wrap.
- `BR_PERF_CNT_EN` undefined: the counter ports and logic are absent from the module entirely.

## Structure
- `br_pkg` holds:
  - `br_type_e` enum, with the encoding above;
  - `BR_NONE`, `BR_JUMP` constants;
  - default `XLEN`.
- Sub-module `br_compare`: purely combinational. Takes type and operands; outputs taken.
- The top level holds the prediction check, the output register and the counters.

## Test plan
- BLT with rdata1=0xFFFFFFFF, rdata2=1, pred_taken=0, target=0x100, pc=0x40: next cycle `br_taken_o`=1, `redirect_o`=1, `redirect_pc_o`=0x100. Same operands as BLTU: taken=0, no redirect.
- BNE with rdata1 equal to rdata2 (5), pred_taken=1, pc=0xFFFFFFFC: `redirect_o`=1, `redirect_pc_o`=0x0 (wrap).
- JUMP, pred_taken=1, pred_target=0x200, target=0x204: `redirect_o`=1, `redirect_pc_o`=0x204. With matching target: `redirect_o`=0.
- Mispredicting BEQ loaded, then `stall_i` held for 3 cycles: `redirect_o` stays 1 throughout. `flush_i` and `stall_i` together: next cycle `valid_o`=0 and `redirect_o`=0.
- `rst_n` pulsed low between clock edges while `redirect_o`=1: outputs drop to 0 immediately.
- With `BR_PERF_CNT_EN` and CNT_W=4: 20 mispredicting branches give `br_count_o`=15 and `mispred_count_o`=15 (saturated). NONE-type and stalled cycles leave the counts unchanged.
